ifu_ibuf: RTL and testbench
===========================

# ifu_ibuf

Instruction buffer on the receive side of the fetch interface. Accepts 4-wide fetch packets (128-bit line, 4×32-bit slots) with a per-slot valid mask, compacts the valid slots into an in-order circular queue, and issues up to 2 instructions per cycle to decode. Sits between instruction fetch and decode. Provides backpressure to fetch and a flush for redirects.

## Interface
Parameters:
- `DEPTH`, default 16: queue entries, one instruction per entry. Power of 2, at least 8.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `flush`, in, 1: discard all contents and any same-cycle enqueue.
- `fetch_valid`, in, 1: fetch packet present.
- `fetch_ready`, out, 1: buffer can take a full packet.
- `fetch_pc`, in, 64: 16-byte-aligned line address of the packet.
- `fetch_inst`, in, 128: slot k is `[32k+31:32k]`.
- `fetch_mask`, in, 4: slot valid bits. Always a contiguous run (e.g. 1111, 1100, 0011, 0110, 0000).
- `dec0_valid`, out, 1: oldest instruction valid.
- `dec0_inst`, out, 32: oldest instruction.
- `dec0_pc`, out, 64: PC of the oldest instruction.
- `dec1_valid`, out, 1: second-oldest instruction valid.
- `dec1_inst`, out, 32: second-oldest instruction.
- `dec1_pc`, out, 64: PC of the second-oldest instruction.
- `dec_ready`, in, 1: decode accepts every presented valid instruction this cycle.

## Operation
- State: `head` and `tail` pointers, each `$clog2(DEPTH)` bits and wrapping modulo DEPTH. `count` is `$clog2(DEPTH)+1` bits. Storage array of {pc, inst}.
- Enqueue fires when `fetch_valid & fetch_ready & ~flush`.
  - The valid slots are written in slot order to `tail`, `tail+1`, and so on.
  - Slot k gets PC `fetch_pc + 4k`.
  - `tail` advances by popcount(`fetch_mask`).
  - A mask of 0000 is a legal handshake that writes nothing.
- `fetch_ready = (DEPTH - count) >= 4`. It depends on registered state only and never on `dec_ready` in the same cycle.
- Dequeue:
  - `dec0_valid = count >= 1` and `dec1_valid = count >= 2`. `dec1_valid` implies `dec0_valid`.
  - Data outputs are read combinationally at `head` and `head+1`.
  - Dequeue fires when `dec_ready & dec0_valid & ~flush`. `head` advances by `dec0_valid + dec1_valid`.
- Enqueue and dequeue in the same cycle: `count_next = count + n_enq - n_deq`. Both happen; no ordering hazard, because enqueue writes only free entries.
- `flush` has the highest priority. Next cycle: `head = tail = 0`, `count = 0`, no write performed.
- Data outputs when the matching valid is 0 are don't-care. The bench checks them only when valid.

## Timing
- Reset, asynchronous, sets `head`, `tail` and `count` to 0. Storage is not reset.
  - Output values in and after reset: `dec0_valid = 0`, `dec1_valid = 0`, `fetch_ready = 1`.
- Latency: an instruction enqueued at edge N is visible on `dec0`/`dec1` in cycle N+1. Zero-cycle bypass is forbidden.
- Throughput: up to 4 instructions in and 2 out per cycle.
- Full boundary: `count > DEPTH-4` drops `fetch_ready` even if decode drains that cycle. `count` never exceeds DEPTH.
- Wrap-around: a packet straddling index DEPTH-1 → 0 is written contiguously modulo DEPTH.
- Reset asserted mid-operation empties the queue immediately (asynchronous). In-flight handshakes are lost.

## Structure
- Shared package `ifu_pkg`:
  - Constants `INST_W=32`, `PC_W=64`, `FETCH_W=4`, `DEC_W=2`.
  - `typedef struct packed {logic [PC_W-1:0] pc; logic [INST_W-1:0] inst;} ibuf_entry_t`.
- Sub-module `ifu_ibuf_compact`, purely combinational:
  - Inputs: `fetch_mask`, `fetch_inst`, `fetch_pc`.
  - Outputs: 4 packed `ibuf_entry_t` lanes, lane-valid bits, and `n_enq` (3 bits).
  - `ifu_ibuf` instantiates it once and holds all sequential state.

## Test plan
- Reset, then enqueue mask 1111, `fetch_pc=0x1000`, slots A,B,C,D.
  - Cycle+1: `dec0 = A@0x1000`, `dec1 = B@0x1004`.
  - With `dec_ready=1` held: next cycle `C@0x1008` / `D@0x100C`; after that, both valids 0.
- Enqueue mask 1100 at `fetch_pc=0x2000`: entries `slot2@0x2008`, `slot3@0x200C`. Then mask 0011 at 0x3000: `slot0@0x3000`, `slot1@0x3004`. Order preserved.
- `DEPTH=16`, `dec_ready=0`, four full packets: `count=16`. `fetch_ready` goes 0 once `count=16`, i.e. `count > 12`.
  - One dequeue of 2 leaves 14; `fetch_ready` stays 0.
  - Two more dequeues leave 10; `fetch_ready` returns to 1.
- Wrap: `head = tail = 14`, enqueue 4 → entries 14, 15, 0, 1. Dequeue returns them in order with correct PCs.
- `flush` in the same cycle as an enqueue and a dequeue: next cycle `count=0`, both valids 0, `fetch_ready=1`. The flushed packet never appears.
- Assert `rst` asynchronously with `count=6` mid-cycle: valids drop before the next edge. After release, the first enqueue appears from index 0.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction-fetch unit.
//   INST_W  : instruction width in bits
//   PC_W    : program-counter width in bits
//   FETCH_W : instruction slots per fetch packet
//   DEC_W   : instructions issued to decode per cycle
//   ibuf_entry_t : one buffered instruction with its PC
package ifu_pkg;

  localparam int INST_W  = 32;
  localparam int PC_W    = 64;
  localparam int FETCH_W = 4;
  localparam int DEC_W   = 2;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ibuf_entry_t;

endpackage

// File: rtl/ifu_ibuf_compact.sv
// ifu_ibuf_compact: packs the valid slots of a fetch packet into the lowest
// lanes, in slot order, and attaches each slot's PC. Purely combinational.
//   fetch_mask : per-slot valid bits
//   fetch_inst : slot k at [32k+31:32k]
//   fetch_pc   : 16-byte-aligned line address
//   lane       : compacted {pc, inst} entries, lane 0 is the oldest
//   lane_valid : lane occupancy (a thermometer code)
//   n_enq      : number of valid slots
module ifu_ibuf_compact
  import ifu_pkg::*;
(
  input  logic [FETCH_W-1:0]        fetch_mask,
  input  logic [FETCH_W*INST_W-1:0] fetch_inst,
  input  logic [PC_W-1:0]           fetch_pc,
  output ibuf_entry_t [FETCH_W-1:0] lane,
  output logic [FETCH_W-1:0]        lane_valid,
  output logic [2:0]                n_enq
);

  logic [2:0] idx;

  // Running count of valid slots seen so far selects the destination lane.
  always_comb begin
    lane       = '0;
    lane_valid = '0;
    idx        = 3'd0;
    for (int k = 0; k < FETCH_W; k++) begin
      if (fetch_mask[k]) begin
        lane[idx[1:0]].pc   = fetch_pc + PC_W'(4 * k);
        lane[idx[1:0]].inst = fetch_inst[INST_W*k +: INST_W];
        lane_valid[idx[1:0]] = 1'b1;
        idx = idx + 3'd1;
      end
    end
    n_enq = idx;
  end

endmodule

// File: rtl/ifu_ibuf.sv
// ifu_ibuf: instruction buffer between fetch and decode. Accepts 4-wide
// fetch packets, stores the valid slots in an in-order circular queue and
// presents the two oldest entries to decode.
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : drop all contents and any same-cycle enqueue
//   fetch_valid/ready   : fetch handshake (ready = room for a full packet)
//   fetch_pc/inst/mask  : fetch packet
//   dec0_* / dec1_*     : oldest / second-oldest instruction
//   dec_ready           : decode takes every presented valid instruction
module ifu_ibuf
  import ifu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        fetch_valid,
  output logic                        fetch_ready,
  input  logic [PC_W-1:0]             fetch_pc,
  input  logic [FETCH_W*INST_W-1:0]   fetch_inst,
  input  logic [FETCH_W-1:0]          fetch_mask,
  output logic                        dec0_valid,
  output logic [INST_W-1:0]           dec0_inst,
  output logic [PC_W-1:0]             dec0_pc,
  output logic                        dec1_valid,
  output logic [INST_W-1:0]           dec1_inst,
  output logic [PC_W-1:0]             dec1_pc,
  input  logic                        dec_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ibuf_entry_t               mem_q [DEPTH];
  logic [PTR_W-1:0]          head_q, head_d;
  logic [PTR_W-1:0]          tail_q, tail_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [PTR_W-1:0]          head1;

  ibuf_entry_t [FETCH_W-1:0] lane;
  logic [FETCH_W-1:0]        lane_valid;
  logic [2:0]                n_enq;
  logic                      enq_fire;
  logic                      deq_fire;
  logic [1:0]                n_deq;

  ifu_ibuf_compact u_compact (
    .fetch_mask (fetch_mask),
    .fetch_inst (fetch_inst),
    .fetch_pc   (fetch_pc),
    .lane       (lane),
    .lane_valid (lane_valid),
    .n_enq      (n_enq)
  );

  // Ready only from registered occupancy, so fetch never sees a combinational
  // path from dec_ready.
  assign fetch_ready = (count_q <= CNT_W'(DEPTH - FETCH_W));
  assign dec0_valid  = (count_q != '0);
  assign dec1_valid  = (count_q >= CNT_W'(2));

  assign head1     = head_q + PTR_W'(1);
  assign dec0_inst = mem_q[head_q].inst;
  assign dec0_pc   = mem_q[head_q].pc;
  assign dec1_inst = mem_q[head1].inst;
  assign dec1_pc   = mem_q[head1].pc;

  assign enq_fire = fetch_valid & fetch_ready & ~flush;
  assign deq_fire = dec_ready & dec0_valid & ~flush;
  assign n_deq    = deq_fire ? (dec1_valid ? 2'd2 : 2'd1) : 2'd0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(n_deq);
      tail_d  = tail_q + (enq_fire ? PTR_W'(n_enq) : PTR_W'(0));
      count_d = count_q + (enq_fire ? CNT_W'(n_enq) : CNT_W'(0)) - CNT_W'(n_deq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset. Only free entries are written, so a same-cycle
  // dequeue never reads a slot being overwritten. Index wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int j = 0; j < FETCH_W; j++) begin
        if (lane_valid[j]) begin
          mem_q[tail_q + PTR_W'(j)] <= lane[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_ifu_ibuf.sv
module tb_ifu_ibuf;
  import ifu_pkg::*;

  localparam int DEPTH = 16;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         fetch_valid;
  logic         fetch_ready;
  logic [63:0]  fetch_pc;
  logic [127:0] fetch_inst;
  logic [3:0]   fetch_mask;
  logic         dec0_valid, dec1_valid;
  logic [31:0]  dec0_inst, dec1_inst;
  logic [63:0]  dec0_pc, dec1_pc;
  logic         dec_ready;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  ifu_ibuf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_inst(fetch_inst), .fetch_mask(fetch_mask),
    .dec0_valid(dec0_valid), .dec0_inst(dec0_inst), .dec0_pc(dec0_pc),
    .dec1_valid(dec1_valid), .dec1_inst(dec1_inst), .dec1_pc(dec1_pc),
    .dec_ready(dec_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: compare presented outputs with the reference queue,
  // then apply the handshakes that will take effect at the coming edge.
  always @(negedge clk) begin
    int n;
    bit acc;
    if (rst) begin
      exp_q.delete();
      chk("rst_dec0_valid", {63'b0, dec0_valid}, 64'd0);
      chk("rst_dec1_valid", {63'b0, dec1_valid}, 64'd0);
      chk("rst_fetch_ready", {63'b0, fetch_ready}, 64'd1);
    end else begin
      n = exp_q.size();
      chk("dec0_valid", {63'b0, dec0_valid}, 64'(n >= 1));
      chk("dec1_valid", {63'b0, dec1_valid}, 64'(n >= 2));
      chk("fetch_ready", {63'b0, fetch_ready}, 64'(DEPTH - n >= 4));
      if (n >= 1 && dec0_valid) begin
        chk("dec0_inst", {32'b0, dec0_inst}, {32'b0, exp_q[0].inst});
        chk("dec0_pc", dec0_pc, exp_q[0].pc);
      end
      if (n >= 2 && dec1_valid) begin
        chk("dec1_inst", {32'b0, dec1_inst}, {32'b0, exp_q[1].inst});
        chk("dec1_pc", dec1_pc, exp_q[1].pc);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        acc = fetch_valid && (DEPTH - n >= 4);
        if (dec_ready && n >= 1) begin
          void'(exp_q.pop_front());
          if (n >= 2) void'(exp_q.pop_front());
        end
        if (acc) begin
          for (int k = 0; k < 4; k++) begin
            if (fetch_mask[k]) exp_q.push_back('{pc: fetch_pc + 64'(4 * k),
                                                  inst: fetch_inst[32*k +: 32]});
          end
        end
      end
    end
  end

  task automatic step(input logic fv, input logic [3:0] m, input logic [63:0] pc,
                      input logic [127:0] inst, input logic dr, input logic fl);
    @(posedge clk);
    #1;
    fetch_valid = fv;
    fetch_mask  = m;
    fetch_pc    = pc;
    fetch_inst  = inst;
    dec_ready   = dr;
    flush       = fl;
  endtask

  task automatic idle(input logic dr, input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 4'h0, 64'h0, 128'h0, dr, 1'b0);
  endtask

  function automatic logic [127:0] rnd_inst();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] abcd;
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_mask = 4'h0;
    fetch_pc = 64'h0; fetch_inst = 128'h0; dec_ready = 1'b0;
    abcd = {32'hDDDD_000D, 32'hCCCC_000C, 32'hBBBB_000B, 32'hAAAA_000A};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic packet, then drain two per cycle
    step(1'b1, 4'b1111, 64'h1000, abcd, 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 3);

    // Partial masks preserve order
    step(1'b1, 4'b1100, 64'h2000, rnd_inst(), 1'b0, 1'b0);
    step(1'b1, 4'b0011, 64'h3000, rnd_inst(), 1'b0, 1'b0);
    step(1'b1, 4'b0110, 64'h3800, rnd_inst(), 1'b0, 1'b0);
    step(1'b1, 4'b0000, 64'h3900, rnd_inst(), 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 4);

    // Fill to DEPTH, then watch fetch_ready as it drains 2 per cycle
    for (int p = 0; p < 4; p++) step(1'b1, 4'b1111, 64'h4000 + 64'(16 * p), rnd_inst(), 1'b0, 1'b0);
    step(1'b1, 4'b1111, 64'h4800, rnd_inst(), 1'b0, 1'b0);
    idle(1'b1, 1);
    idle(1'b0, 1);
    idle(1'b1, 2);
    idle(1'b0, 1);
    idle(1'b1, 6);

    // Wrap: bring head and tail to 14, then straddle the end
    step(1'b0, 4'h0, 64'h0, 128'h0, 1'b0, 1'b1);
    for (int p = 0; p < 3; p++) step(1'b1, 4'b1111, 64'h5000 + 64'(16 * p), rnd_inst(), 1'b0, 1'b0);
    step(1'b1, 4'b0011, 64'h5030, rnd_inst(), 1'b0, 1'b0);
    idle(1'b1, 8);
    chk("wrap_head", 64'(dut.head_q), 64'd14);
    chk("wrap_tail", 64'(dut.tail_q), 64'd14);
    step(1'b1, 4'b1111, 64'h6000, rnd_inst(), 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 3);

    // Flush together with enqueue and dequeue
    step(1'b1, 4'b1111, 64'h7000, rnd_inst(), 1'b0, 1'b0);
    step(1'b1, 4'b1111, 64'h7010, rnd_inst(), 1'b0, 1'b0);
    step(1'b1, 4'b1111, 64'h7020, rnd_inst(), 1'b1, 1'b1);
    idle(1'b1, 2);

    // Asynchronous reset mid-cycle with six entries held
    step(1'b1, 4'b1111, 64'h8000, rnd_inst(), 1'b0, 1'b0);
    step(1'b1, 4'b0011, 64'h8010, rnd_inst(), 1'b0, 1'b0);
    idle(1'b0, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_dec0_valid", {63'b0, dec0_valid}, 64'd0);
    chk("async_dec1_valid", {63'b0, dec1_valid}, 64'd0);
    chk("async_fetch_ready", {63'b0, fetch_ready}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_tail", 64'(dut.tail_q), 64'd0);
    step(1'b1, 4'b1111, 64'h9000, abcd, 1'b0, 1'b0);
    idle(1'b0, 1);
    chk("post_rst_mem0", {32'b0, dut.mem_q[0].inst}, 64'hAAAA_000A);
    idle(1'b1, 3);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      int s, len;
      s   = $urandom_range(0, 3);
      len = $urandom_range(0, 4 - s);
      step(1'($urandom_range(0, 3) != 0), 4'(((1 << len) - 1) << s),
           64'({$urandom, $urandom}) & ~64'hF, rnd_inst(),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end
    idle(1'b1, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
